// File: rtl/hdmi_fb_scanout_arbiter.sv
// hdmi_fb_scanout_arbiter
// Shares one single-port framebuffer RAM between HDMI scanout reads and
// camera pixel writes. Follows the transceiver raster and upscales a
// 2^S-reduced framebuffer. Scanout reads only on the first pixel of each
// 2^S group; every other slot, and all of blanking, belongs to the writer.
module hdmi_fb_scanout_arbiter #(
    parameter int H_PIXEL     = 1280,
    parameter int V_PIXEL     = 720,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_ADDR_W   = 16,
    parameter int PIX_W       = 24
) (
    input  logic                 pixclk,
    input  logic                 reset,
    input  logic [20:0]          addr,
    input  logic                 vid_active,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]     wr_data,
    output logic                 wr_err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]     mem_wdata,
    input  logic [PIX_W-1:0]     mem_rdata,
    output logic [7:0]           red,
    output logic [7:0]           green,
    output logic [7:0]           blue,
    output logic                 frame_tick
);

    localparam int XW      = $clog2(H_PIXEL);
    localparam int YW      = $clog2(V_PIXEL);
    localparam int FB_W    = H_PIXEL >> SCALE_SHIFT;
    localparam int FB_SIZE = FB_W * (V_PIXEL >> SCALE_SHIFT);
    localparam int GRP_M   = (1 << SCALE_SHIFT) - 1;

    localparam logic [XW-1:0]        X_LAST    = XW'(H_PIXEL - 1);
    localparam logic [YW-1:0]        Y_LAST    = YW'(V_PIXEL - 1);
    localparam logic [XW-1:0]        X_MASK    = XW'(GRP_M);
    localparam logic [YW-1:0]        Y_MASK    = YW'(GRP_M);
    localparam logic [FB_ADDR_W-1:0] ROW_STEP  = FB_ADDR_W'(FB_W);
    localparam logic [FB_ADDR_W:0]   FB_LIMIT  = (FB_ADDR_W + 1)'(FB_SIZE);

    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    logic [FB_ADDR_W-1:0] row_base;
    logic                 synced;
    logic                 act_d1;
    logic                 rd_d1;
    logic [PIX_W-1:0]     hold;
    logic [PIX_W-1:0]     rgb;

    logic                 resync;
    logic [XW-1:0]        x_cur;
    logic [YW-1:0]        y_cur;
    logic [FB_ADDR_W-1:0] rb_cur;
    logic                 scan_req;
    logic                 wr_in_range;
    logic [FB_ADDR_W-1:0] rd_addr;

    // addr==0 during active video pins the raster to the frame origin this
    // very cycle, so the read issued now already uses the corrected position.
    assign resync      = vid_active && (addr == '0);
    assign x_cur       = resync ? '0 : x;
    assign y_cur       = resync ? '0 : y;
    assign rb_cur      = resync ? '0 : row_base;
    assign scan_req    = vid_active && ((x_cur & X_MASK) == '0);
    assign rd_addr     = rb_cur + FB_ADDR_W'(x_cur >> SCALE_SHIFT);
    assign wr_in_range = {1'b0, wr_addr} < FB_LIMIT;

    // Single owner per cycle: scanout read first, otherwise the writer.
    always_comb begin
        wr_ready  = reset && !scan_req;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            if (scan_req) begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end else if (wr_valid && wr_in_range) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
            end
        end
    end

    // Raster counters, FB row base and end-of-frame pulse.
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            x          <= '0;
            y          <= '0;
            row_base   <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (vid_active) begin
                if (x_cur == X_LAST) begin
                    x <= '0;
                    if (y_cur == Y_LAST) begin
                        y          <= '0;
                        row_base   <= '0;
                        frame_tick <= 1'b1;
                    end else begin
                        y        <= y_cur + 1'b1;
                        // Advance one FB row after the last screen line of each group.
                        row_base <= ((y_cur & Y_MASK) == Y_MASK) ? rb_cur + ROW_STEP : rb_cur;
                    end
                end else begin
                    x        <= x_cur + 1'b1;
                    y        <= y_cur;
                    row_base <= rb_cur;
                end
            end
        end
    end

    // Dropped out-of-range writes are reported one cycle after acceptance.
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) wr_err <= 1'b0;
        else        wr_err <= wr_ready && wr_valid && !wr_in_range;
    end

    // Two-stage pixel pipeline; output stays black until the raster has been
    // aligned by an addr==0 resync since the last reset.
    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            synced <= 1'b0;
            act_d1 <= 1'b0;
            rd_d1  <= 1'b0;
            hold   <= '0;
            rgb    <= '0;
        end else begin
            synced <= synced || resync;
            act_d1 <= vid_active && (synced || resync);
            rd_d1  <= scan_req;
            if (rd_d1) hold <= mem_rdata;
            if (act_d1) rgb <= rd_d1 ? mem_rdata : hold;
            else        rgb <= '0;
        end
    end

    assign red   = rgb[PIX_W-1 -: 8];
    assign green = rgb[PIX_W-9 -: 8];
    assign blue  = rgb[PIX_W-17 -: 8];

endmodule

// File: tb/tb_hdmi_fb_scanout_arbiter.sv
// Bench for hdmi_fb_scanout_arbiter: a table of per-cycle vectors plus
// hand-written raster, frame and reset sequences. RAM word k holds value k.
// A second, reduced-size instance (16x8 screen) covers the frame wrap.
module tb_hdmi_fb_scanout_arbiter;

    logic        pixclk = 1'b0;
    logic        reset;
    logic [20:0] addr;
    logic        vid_active;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [23:0] wr_data;

    logic        wr_ready, wr_err, mem_en, mem_we, frame_tick;
    logic [15:0] mem_addr;
    logic [23:0] mem_wdata, mem_rdata;
    logic [7:0]  red, green, blue;

    logic        wr_ready_s, wr_err_s, mem_en_s, mem_we_s, frame_tick_s;
    logic [15:0] mem_addr_s;
    logic [23:0] mem_wdata_s, mem_rdata_s;
    logic [7:0]  red_s, green_s, blue_s;

    int nvec = 0;
    int nerr = 0;

    always #5 pixclk = ~pixclk;

    hdmi_fb_scanout_arbiter dut (
        .pixclk(pixclk), .reset(reset), .addr(addr), .vid_active(vid_active),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .red(red), .green(green),
        .blue(blue), .frame_tick(frame_tick)
    );

    hdmi_fb_scanout_arbiter #(.H_PIXEL(16), .V_PIXEL(8)) dut_s (
        .pixclk(pixclk), .reset(reset), .addr(addr), .vid_active(vid_active),
        .wr_valid(wr_valid), .wr_ready(wr_ready_s), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err_s), .mem_en(mem_en_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata_s), .red(red_s), .green(green_s),
        .blue(blue_s), .frame_tick(frame_tick_s)
    );

    // Synchronous-read RAM models: word k = k.
    always @(posedge pixclk) begin
        if (mem_en && !mem_we)     mem_rdata   <= {8'd0, mem_addr};
        if (mem_en_s && !mem_we_s) mem_rdata_s <= {8'd0, mem_addr_s};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, return at the falling edge.
    task automatic apply(input logic rst, input logic va, input logic [20:0] a,
                         input logic wv, input logic [15:0] wa);
        @(posedge pixclk);
        #1;
        reset = rst; vid_active = va; addr = a; wr_valid = wv; wr_addr = wa;
        wr_data = {8'hA5, wa};
        @(negedge pixclk);
    endtask

    typedef struct packed {
        logic        va;
        logic [20:0] a;
        logic        wv;
        logic [15:0] wa;
        logic        rdy;
        logic        en;
        logic        we;
        logic [15:0] ma;
        logic [23:0] rgb;
        logic        err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int rdy_bad, nwr, nrd, nz, ticks;

        //           va a   wv wa     rdy en we ma     rgb err
        tbl[0]  = '{1'b0, 21'd0, 1'b1, 16'd5,     1'b1, 1'b1, 1'b1, 16'd5,     24'd0, 1'b0};
        tbl[1]  = '{1'b0, 21'd0, 1'b1, 16'd57600, 1'b1, 1'b0, 1'b0, 16'd0,     24'd0, 1'b0};
        tbl[2]  = '{1'b0, 21'd0, 1'b1, 16'd57599, 1'b1, 1'b1, 1'b1, 16'd57599, 24'd0, 1'b1};
        tbl[3]  = '{1'b1, 21'd0, 1'b1, 16'd7,     1'b0, 1'b1, 1'b0, 16'd0,     24'd0, 1'b0};
        tbl[4]  = '{1'b1, 21'd1, 1'b1, 16'd8,     1'b1, 1'b1, 1'b1, 16'd8,     24'd0, 1'b0};
        tbl[5]  = '{1'b1, 21'd2, 1'b0, 16'd0,     1'b1, 1'b0, 1'b0, 16'd0,     24'd0, 1'b0};
        tbl[6]  = '{1'b1, 21'd3, 1'b1, 16'd9,     1'b1, 1'b1, 1'b1, 16'd9,     24'd0, 1'b0};
        tbl[7]  = '{1'b1, 21'd4, 1'b1, 16'd10,    1'b0, 1'b1, 1'b0, 16'd1,     24'd0, 1'b0};
        tbl[8]  = '{1'b1, 21'd5, 1'b0, 16'd0,     1'b1, 1'b0, 1'b0, 16'd0,     24'd0, 1'b0};
        tbl[9]  = '{1'b0, 21'd0, 1'b0, 16'd0,     1'b1, 1'b0, 1'b0, 16'd0,     24'd1, 1'b0};
        tbl[10] = '{1'b0, 21'd0, 1'b0, 16'd0,     1'b1, 1'b0, 1'b0, 16'd0,     24'd1, 1'b0};
        tbl[11] = '{1'b0, 21'd0, 1'b0, 16'd0,     1'b1, 1'b0, 1'b0, 16'd0,     24'd0, 1'b0};

        reset = 1'b0; vid_active = 1'b0; addr = '0; wr_valid = 1'b1;
        wr_addr = 16'd3; wr_data = '0;

        // Reset holds the RAM port idle even with a pending write.
        repeat (2) @(negedge pixclk);
        chk("rst mem_en", mem_en, 0);
        chk("rst wr_ready", wr_ready, 0);
        chk("rst rgb", {red, green, blue}, 0);
        chk("rst frame_tick", frame_tick, 0);
        apply(1, 0, 0, 0, 0);
        chk("release wr_ready", wr_ready, 1);
        chk("release mem_en", mem_en, 0);

        // Table: range check, resync, arbitration and first-pixel latency.
        for (int i = 0; i < 12; i++) begin
            apply(1, tbl[i].va, tbl[i].a, tbl[i].wv, tbl[i].wa);
            chk($sformatf("v%0d wr_ready", i), wr_ready, tbl[i].rdy);
            chk($sformatf("v%0d mem_en", i), mem_en, tbl[i].en);
            chk($sformatf("v%0d mem_we", i), mem_we, tbl[i].we);
            chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].ma);
            chk($sformatf("v%0d rgb", i), {red, green, blue}, tbl[i].rgb);
            chk($sformatf("v%0d wr_err", i), wr_err, tbl[i].err);
        end

        // Four full lines plus a little, writer always requesting.
        rdy_bad = 0; nwr = 0; nrd = 0;
        for (int k = 0; k <= 5122; k++) begin
            apply(1, 1, 21'(k), 1, 16'd100);
            if (k < 5120) begin
                if (wr_ready !== ((k % 4) != 0)) rdy_bad++;
                if (mem_en && mem_we) nwr++;
                if (mem_en && !mem_we) nrd++;
            end
            if (k >= 2 && k <= 5) chk($sformatf("line0 px%0d rgb", k - 2), {red, green, blue}, 0);
            if (k == 6) chk("line0 px4 rgb", {red, green, blue}, 1);
            if (k == 5120) begin
                chk("line4 x0 mem_addr", mem_addr, 320);
                chk("line4 x0 mem_we", mem_we, 0);
            end
            if (k == 5122) chk("line4 x0 rgb", {red, green, blue}, 320);
        end
        chk("ready pattern errors", rdy_bad, 0);
        chk("writes in 4 lines", nwr, 3840);
        chk("reads in 4 lines", nrd, 1280);

        // Mid-frame addr==0 glitch realigns to the origin.
        apply(1, 1, 0, 1, 16'd100);
        chk("glitch mem_addr", mem_addr, 0);
        chk("glitch wr_ready", wr_ready, 0);
        apply(1, 1, 1, 1, 16'd100);
        chk("glitch+1 wr_ready", wr_ready, 1);
        apply(1, 1, 2, 0, 0);
        apply(1, 1, 3, 0, 0);
        apply(1, 1, 4, 0, 0);
        chk("glitch x4 mem_addr", mem_addr, 1);

        // Frame wrap on the 16x8 instance: exactly one tick after the last pixel.
        apply(1, 0, 0, 0, 0);
        ticks = 0;
        for (int k = 0; k < 128; k++) begin
            apply(1, 1, 21'(k), 0, 0);
            ticks += int'(frame_tick_s);
        end
        chk("frame ticks in frame", ticks, 0);
        apply(1, 0, 0, 0, 0);
        chk("frame_tick after last", frame_tick_s, 1);
        apply(1, 1, 0, 0, 0);
        chk("frame_tick one cycle", frame_tick_s, 0);
        chk("next frame mem_en", mem_en_s, 1);
        chk("next frame mem_addr", mem_addr_s, 0);

        // Reset mid-line at x=37, then black until the next resync.
        for (int k = 0; k < 37; k++) apply(1, 1, 21'(k), 0, 0);
        apply(0, 1, 37, 1, 16'd4);
        chk("midrst mem_en", mem_en, 0);
        chk("midrst wr_ready", wr_ready, 0);
        chk("midrst rgb", {red, green, blue}, 0);
        nz = 0;
        for (int k = 38; k < 78; k++) begin
            apply(1, 1, 21'(k), 0, 0);
            if ({red, green, blue} != 0) nz++;
        end
        chk("unsynced nonblack", nz, 0);
        for (int k = 0; k <= 6; k++) begin
            apply(1, 1, 21'(k), 0, 0);
            if (k == 5) chk("resumed px3 rgb", {red, green, blue}, 0);
            if (k == 6) chk("resumed px4 rgb", {red, green, blue}, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
